jpeg_bitstream_packer: RTL and testbench
========================================

# jpeg_bitstream_packer

Packs the variable-length Huffman codes produced by the Huffman encode controller (DC code/amplitude and AC code/amplitude pairs) into an MSB-first byte stream for the JPEG entropy-coded segment. It sits directly downstream of `HW_JPEGenc` and upstream of the output FIFO/host interface. Every 0xFF data byte is followed by a stuffed 0x00. At end of scan, a flush pads the last partial byte with 1s.

## Interface
- `ACC_WIDTH`, 64: bit accumulator width.
- `CODE_WIDTH`, 32: maximum code length accepted per beat.
- `clock`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `code_valid`  in  1: code beat present.
- `code_ready`  out  1: packer accepts the beat this cycle (combinational).
- `code_data`  in  32: code, right-aligned; bits at and above `code_len` are ignored.
- `code_len`  in  6: number of valid bits, 0..32.
- `flush`  in  1: single-cycle end-of-scan request.
- `out_valid`  out  1: `out_byte` valid.
- `out_ready`  in  1: downstream accepts the byte.
- `out_byte`  out  8: stream byte.
- `busy`  out  1: bits held, flush in progress, or `out_valid` high.
- `done`  out  1: one-cycle pulse when a flush completes.
- `len_err`  out  1: sticky; set when `code_len` > 32. Cleared only by reset.

## Operation
- The accumulator `acc[63:0]` holds valid bits left-justified in `acc[63:64-bit_cnt]`. `bit_cnt` is 7 bits, range 0..64.
- `code_ready` = state RUN && `bit_cnt` <= 32.
  - On accept, the low `code_len` bits of `code_data` are ORed in immediately below the current valid bits.
  - `code_len` = 0 is accepted as a no-op.
  - `code_len` > 32 is treated as 32 and sets `len_err`.
- Output stage: a single register (`out_byte`, `out_valid`). It loads when `!out_valid || out_ready`, using this priority:
  1. `stuff_pend` set → load 0x00 and clear `stuff_pend`.
  2. `bit_cnt` >= 8 → load `acc[63:56]`, shift `acc` left by 8, and subtract 8 from `bit_cnt`. If the loaded byte is 0xFF, set `stuff_pend`.
  3. Otherwise → `out_valid` = 0.
- Accept and pop in the same cycle: `bit_cnt_next = bit_cnt - 8*pop + len`. The new code is placed relative to the post-shift position.
- States:
  - RUN: normal operation. `flush` moves to FLUSH. If `code_valid` is accepted in the same cycle as `flush`, that code is included before the flush takes effect.
  - FLUSH: `code_ready` = 0. If `bit_cnt` is 1..7, pad the low bits with 1s up to 8 (one cycle), and the padded byte is then emitted normally. When `bit_cnt` = 0, `stuff_pend` = 0 and the output register has drained (not `out_valid`, or last byte accepted), go to EOI_FF (macro on) or DONE.
  - EOI_FF / EOI_D9: load 0xFF then 0xD9 into the output register. No stuffing is applied to these bytes.
  - DONE: `done` = 1 for one cycle, then return to RUN.
- `flush` received in any state other than RUN is ignored.
- `flush` with an empty accumulator goes straight to DONE (or the EOI bytes when the macro is on).

## Timing
- Reset values:
  - `out_valid` 0, `out_byte` 0x00, `done` 0, `len_err` 0, `busy` 0.
  - State RUN, `bit_cnt` 0, `acc` 0, `stuff_pend` 0, so `code_ready` = 1.
- Reset mid-operation discards all held bits, any pending stuff byte and any flush in progress. No partial byte is emitted.
- Latency: a code accepted at cycle N that brings `bit_cnt` to >= 8 gives `out_valid` = 1 at N+1, if the output register is free.
- Throughput: one byte per cycle while `out_ready` = 1.
- With `out_ready` = 0 and `out_valid` = 1, `out_byte` is held stable. No loss, no duplication.
- 0xFF followed by 0x00 is emitted back-to-back, and no data byte is ever inserted between them.

## Configuration
- `JPEG_PACKER_EOI_EN` defined: after the flush padding has drained, emit 0xFF, 0xD9, then pulse `done`.
- `JPEG_PACKER_EOI_EN` undefined: the EOI_FF and EOI_D9 states are absent; `done` pulses the cycle after the drain completes.

## Structure
- Shared package `jpeg_enc_pkg` holds:
  - the `packer_state_t` enum (RUN, FLUSH, EOI_FF, EOI_D9, DONE);
  - constants `JPEG_MARKER_PREFIX` = 8'hFF, `JPEG_EOI` = 8'hD9, `JPEG_STUFF` = 8'h00.
- One sub-module, `jpeg_byte_stuffer`. It contains the output register, `stuff_pend`, the valid/ready logic and the EOI insert. The top level contains the accumulator and the state machine.

## Test plan
- Codes (0b101, len 3), (0b11111, len 5), then flush → bytes 0xBF; `done` pulses; `busy` drops to 0.
- Code 0xFF (len 8), code 0x12 (len 8) → 0xFF, 0x00, 0x12 in order.
- Code 0x3 (len 2), then flush → 0xFF (1-padded), 0x00, and with the macro on also 0xFF, 0xD9 unstuffed.
- 32-bit code 0xDEADBEEF while `out_ready` is toggled 1,0,0,1,…:
  - bytes DE, AD, BE, EF with no drops;
  - `out_byte` stable while stalled;
  - `code_ready` = 0 whenever `bit_cnt` > 32.
- `code_len` = 40 → `len_err` = 1 and stays set; 32 bits are packed.
- Assert `reset_n` with 13 bits held → `out_valid` = 0, `bit_cnt` 0, `code_ready` = 1, and no byte appears after release.

Source files
------------

// File: rtl/jpeg_enc_pkg.sv
// Shared types and constants for the JPEG entropy-coded segment path.
// Used by jpeg_bitstream_packer and jpeg_byte_stuffer.
package jpeg_enc_pkg;

    typedef enum logic [2:0] {
        RUN,
        FLUSH,
        EOI_FF,
        EOI_D9,
        DONE
    } packer_state_t;

    localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] JPEG_EOI           = 8'hD9;
    localparam logic [7:0] JPEG_STUFF         = 8'h00;

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// Output byte register with 0xFF/0x00 stuffing and marker byte insertion.
// Marker bytes requested through eoi_load are never stuffed.
module jpeg_byte_stuffer
    import jpeg_enc_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       byte_avail,
    input  logic [7:0] acc_byte,
    input  logic       eoi_load,
    input  logic [7:0] eoi_byte,
    input  logic       out_ready,
    output logic       pop,
    output logic       load_en,
    output logic       out_valid,
    output logic [7:0] out_byte,
    output logic       stuff_pend
);

    assign load_en = !out_valid || out_ready;
    assign pop     = load_en && !eoi_load && !stuff_pend && byte_avail;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_byte   <= 8'h00;
            stuff_pend <= 1'b0;
        end else if (load_en) begin
            if (eoi_load) begin
                out_byte  <= eoi_byte;
                out_valid <= 1'b1;
            end else if (stuff_pend) begin
                out_byte   <= JPEG_STUFF;
                out_valid  <= 1'b1;
                stuff_pend <= 1'b0;
            end else if (byte_avail) begin
                out_byte   <= acc_byte;
                out_valid  <= 1'b1;
                stuff_pend <= (acc_byte == JPEG_MARKER_PREFIX);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jpeg_bitstream_packer.sv
// MSB-first Huffman code packer for the JPEG entropy-coded segment.
// Define JPEG_PACKER_EOI_EN to append the FF D9 EOI marker on flush.
module jpeg_bitstream_packer
    import jpeg_enc_pkg::*;
#(
    parameter int ACC_WIDTH  = 64,
    parameter int CODE_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  code_valid,
    output logic                  code_ready,
    input  logic [CODE_WIDTH-1:0] code_data,
    input  logic [5:0]            code_len,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_byte,
    output logic                  busy,
    output logic                  done,
    output logic                  len_err
);

    localparam int CW = $clog2(ACC_WIDTH + 1);
    localparam logic [ACC_WIDTH-1:0] TOP_MASK =
        {8'hFF, {(ACC_WIDTH-8){1'b0}}};

`ifdef JPEG_PACKER_EOI_EN
    localparam packer_state_t DRAIN_NEXT = EOI_FF;
`else
    localparam packer_state_t DRAIN_NEXT = DONE;
`endif

    packer_state_t        state;
    logic [ACC_WIDTH-1:0] acc, acc_n, code_ext;
    logic [CW-1:0]        bit_cnt, cnt_n, base, len_eff, shamt;
    logic                 accept, pop, load_en, stuff_pend;
    logic                 drained, eoi_load;
    logic [7:0]           eoi_byte;

    assign code_ready = (state == RUN) &&
                        (bit_cnt <= CW'(ACC_WIDTH - CODE_WIDTH));
    assign accept     = code_valid && code_ready;
    assign len_eff    = (code_len > 6'(CODE_WIDTH)) ?
                        CW'(CODE_WIDTH) : CW'(code_len);
    assign code_ext   = ACC_WIDTH'(code_data) &
                        ((ACC_WIDTH'(1) << len_eff) - ACC_WIDTH'(1));
    assign base       = bit_cnt - (pop ? CW'(8) : CW'(0));
    assign shamt      = CW'(ACC_WIDTH) - base - len_eff;
    assign drained    = (bit_cnt == '0) && !stuff_pend && load_en;
    assign busy       = (bit_cnt != '0) || (state != RUN) ||
                        out_valid || stuff_pend;

`ifdef JPEG_PACKER_EOI_EN
    assign eoi_load = (state == EOI_FF) || (state == EOI_D9);
    assign eoi_byte = (state == EOI_FF) ? JPEG_MARKER_PREFIX : JPEG_EOI;
`else
    assign eoi_load = 1'b0;
    assign eoi_byte = JPEG_EOI;
`endif

    // New code lands just below the bits that remain after this cycle's pop
    always_comb begin
        acc_n = pop ? (acc << 8) : acc;
        cnt_n = base;
        if (accept) begin
            acc_n = acc_n | (code_ext << shamt);
            cnt_n = base + len_eff;
        end
        if (state == FLUSH && bit_cnt != '0 && bit_cnt < CW'(8)) begin
            acc_n = acc | ((TOP_MASK >> bit_cnt) & TOP_MASK);
            cnt_n = CW'(8);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RUN;
            acc     <= '0;
            bit_cnt <= '0;
            done    <= 1'b0;
            len_err <= 1'b0;
        end else begin
            acc     <= acc_n;
            bit_cnt <= cnt_n;
            done    <= 1'b0;
            if (accept && code_len > 6'(CODE_WIDTH))
                len_err <= 1'b1;
            case (state)
                RUN: begin
                    if (flush) begin
                        if (drained && !accept) begin
                            state <= DRAIN_NEXT;
                            done  <= (DRAIN_NEXT == DONE);
                        end else begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (drained) begin
                        state <= DRAIN_NEXT;
                        done  <= (DRAIN_NEXT == DONE);
                    end
                end
`ifdef JPEG_PACKER_EOI_EN
                EOI_FF: begin
                    if (load_en)
                        state <= EOI_D9;
                end
                EOI_D9: begin
                    if (load_en) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
`endif
                DONE:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    jpeg_byte_stuffer u_stuffer (
        .clock      (clock),
        .reset_n    (reset_n),
        .byte_avail (bit_cnt >= CW'(8)),
        .acc_byte   (acc[ACC_WIDTH-1 -: 8]),
        .eoi_load   (eoi_load),
        .eoi_byte   (eoi_byte),
        .out_ready  (out_ready),
        .pop        (pop),
        .load_en    (load_en),
        .out_valid  (out_valid),
        .out_byte   (out_byte),
        .stuff_pend (stuff_pend)
    );

endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// Directed bench for jpeg_bitstream_packer.
// Expected byte streams follow JPEG_PACKER_EOI_EN when it is defined.
module tb_jpeg_bitstream_packer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        code_valid = 1'b0;
    logic        code_ready;
    logic [31:0] code_data = '0;
    logic [5:0]  code_len = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_byte;
    logic        busy;
    logic        done;
    logic        len_err;

    int tests = 0;
    int fails = 0;
    logic [7:0] q[$];

    always #5 clock = ~clock;

    jpeg_bitstream_packer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_data  (code_data),
        .code_len   (code_len),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .busy       (busy),
        .done       (done),
        .len_err    (len_err)
    );

    always @(posedge clock)
        if (reset_n && out_valid && out_ready)
            q.push_back(out_byte);

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [5:0] l);
        int n = 0;
        code_valid = 1'b1;
        code_data  = d;
        code_len   = l;
        while (!code_ready && n < 100) begin
            tick(1);
            n++;
        end
        if (!code_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout code=%h len=%0d", d, l);
        end
        tick(1);
        code_valid = 1'b0;
    endtask

    task automatic pulse_flush_wait(output bit seen);
        seen  = 1'b0;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        if (done) seen = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick(1);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        tests++;
        if (out_valid !== 1'b0 || out_byte !== 8'h00 || done !== 1'b0 ||
            len_err !== 1'b0 || busy !== 1'b0 || code_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset got v=%b b=%h d=%b e=%b busy=%b rdy=%b want 0 00 0 0 0 1",
                     out_valid, out_byte, done, len_err, busy, code_ready);
        end
    endtask

    task automatic test_pack_flush();
        logic [7:0] exp[$];
        bit seen;
`ifdef JPEG_PACKER_EOI_EN
        exp = '{8'hBF, 8'hFF, 8'hD9};
`else
        exp = '{8'hBF};
`endif
        q.delete();
        out_ready = 1'b1;
        send(32'h5, 6'd3);
        send(32'h1F, 6'd5);
        pulse_flush_wait(seen);
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL pack_flush_done got no pulse want pulse");
        end
        tick(1);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL pack_flush_idle got done=%b busy=%b want 0 0", done, busy);
        end
        tests++;
        if (q.size() != exp.size()) begin
            fails++;
            $display("FAIL pack_flush_count got %0d want %0d", q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++)
                if (q[i] !== exp[i]) begin
                    fails++;
                    $display("FAIL pack_flush_byte%0d got %h want %h", i, q[i], exp[i]);
                end
        end
    endtask

    task automatic test_stuffing();
        logic [7:0] exp[$];
        exp = '{8'hFF, 8'h00, 8'h12};
        q.delete();
        out_ready = 1'b1;
        send(32'hFF, 6'd8);
        send(32'h12, 6'd8);
        tick(8);
        tests++;
        if (q.size() != exp.size()) begin
            fails++;
            $display("FAIL stuff_count got %0d want %0d", q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++)
                if (q[i] !== exp[i]) begin
                    fails++;
                    $display("FAIL stuff_byte%0d got %h want %h", i, q[i], exp[i]);
                end
        end
    endtask

    task automatic test_pad_flush();
        logic [7:0] exp[$];
        bit seen;
`ifdef JPEG_PACKER_EOI_EN
        exp = '{8'hFF, 8'h00, 8'hFF, 8'hD9};
`else
        exp = '{8'hFF, 8'h00};
`endif
        q.delete();
        out_ready = 1'b1;
        send(32'h3, 6'd2);
        pulse_flush_wait(seen);
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL pad_done got no pulse want pulse");
        end
        tick(2);
        tests++;
        if (q.size() != exp.size()) begin
            fails++;
            $display("FAIL pad_count got %0d want %0d", q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++)
                if (q[i] !== exp[i]) begin
                    fails++;
                    $display("FAIL pad_byte%0d got %h want %h", i, q[i], exp[i]);
                end
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [7:0] exp[$];
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'h77};
        q.delete();
        out_ready = 1'b0;
        send(32'hDEADBEEF, 6'd32);
        send(32'hCAFE, 6'd16);
        tests++;
        if (code_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_ready_40bits got %b want 0", code_ready);
        end
        tests++;
        if (out_valid !== 1'b1 || out_byte !== 8'hDE) begin
            fails++;
            $display("FAIL stall_first got v=%b b=%h want 1 de", out_valid, out_byte);
        end
        fork
            send(32'h77, 6'd8);
            begin
                for (int i = 0; i < 40; i++) begin
                    logic       hold;
                    logic [7:0] hb;
                    out_ready = pat[i % 4];
                    hold = out_valid && !out_ready;
                    hb   = out_byte;
                    tick(1);
                    if (hold) begin
                        tests++;
                        if (out_valid !== 1'b1 || out_byte !== hb) begin
                            fails++;
                            $display("FAIL stall_hold got v=%b b=%h want 1 %h",
                                     out_valid, out_byte, hb);
                        end
                    end
                end
            end
        join
        out_ready = 1'b1;
        tick(10);
        tests++;
        if (q.size() != exp.size()) begin
            fails++;
            $display("FAIL stall_count got %0d want %0d", q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++)
                if (q[i] !== exp[i]) begin
                    fails++;
                    $display("FAIL stall_byte%0d got %h want %h", i, q[i], exp[i]);
                end
        end
    endtask

    task automatic test_len_err();
        logic [7:0] exp[$];
        exp = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAB};
        q.delete();
        out_ready = 1'b1;
        tests++;
        if (len_err !== 1'b0) begin
            fails++;
            $display("FAIL len_err_pre got %b want 0", len_err);
        end
        send(32'h12345678, 6'd40);
        tests++;
        if (len_err !== 1'b1) begin
            fails++;
            $display("FAIL len_err_set got %b want 1", len_err);
        end
        send(32'hAB, 6'd8);
        tick(10);
        tests++;
        if (len_err !== 1'b1) begin
            fails++;
            $display("FAIL len_err_sticky got %b want 1", len_err);
        end
        tests++;
        if (q.size() != exp.size()) begin
            fails++;
            $display("FAIL len_err_count got %0d want %0d", q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++)
                if (q[i] !== exp[i]) begin
                    fails++;
                    $display("FAIL len_err_byte%0d got %h want %h", i, q[i], exp[i]);
                end
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        send(32'h1ABC, 6'd13);
        tick(1);
        tests++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_pre got v=%b busy=%b want 1 1", out_valid, busy);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || code_ready !== 1'b1 || busy !== 1'b0 ||
            len_err !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset got v=%b rdy=%b busy=%b err=%b want 0 1 0 0",
                     out_valid, code_ready, busy, len_err);
        end
        tick(1);
        reset_n = 1'b1;
        out_ready = 1'b1;
        q.delete();
        tick(10);
        tests++;
        if (q.size() != 0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_after got n=%0d v=%b busy=%b want 0 0 0",
                     q.size(), out_valid, busy);
        end
    endtask

    initial begin
        #1;
        test_reset();
        tick(2);
        reset_n = 1'b1;
        tick(1);
        test_reset();
        test_pack_flush();
        test_stuffing();
        test_pad_flush();
        test_back_to_back_stall();
        test_len_err();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
